wb_commit: RTL

- Write-back/commit stage. Consumes the registered WB-side bundle produced by the MEM/WB pipeline register, i.e. the wr_* signals.
- Drives the register-file write port.
- Owns the architectural HI/LO registers and a minimal CP0: Count, Compare, Status, Cause and EPC.
- Raises a one-cycle redirect to fetch on SYSCALL, BREAK and ERET.

---
 rtl/wb_commit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/wb_commit.sv
// wb_commit: write-back / commit stage.
// Takes the registered MEM/WB bundle (wr_*) and:
//   - drives the register-file write port (rf_we/rf_waddr/rf_wdata), combinationally
//   - owns the architectural HI/LO registers (hi_o/lo_o)
//   - owns a minimal CP0: Count, Compare, Status (status_o), Cause, EPC
//   - raises a one-cycle redirect (exc_flush/exc_target) on SYSCALL, BREAK and ERET
//   - exports the timer interrupt request (timer_int)
// Clk: rising-edge clock. Reset: synchronous, active-high.
// Reads of HI/LO/CP0 always return the pre-edge value (no same-cycle bypass).
module wb_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        wr_valid,
  input  logic [31:0] wr_dout,
  input  logic [31:0] wr_alu_result,
  input  logic [4:0]  wr_Rw,
  input  logic        wr_RegWr,
  input  logic        wr_MemtoReg,
  input  logic [31:0] wr_busA,
  input  logic [63:0] wr_mul_result,
  input  logic [1:0]  wr_regToMul,
  input  logic        wr_mulToReg,
  input  logic        wr_mulRead,
  input  logic [4:0]  wr_cs,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_busB,
  input  logic [2:0]  wr_cp0Op,
  input  logic [29:0] wr_PC,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] status_o,
  output logic        exc_flush,
  output logic [29:0] exc_target,
  output logic        timer_int
);

  localparam logic [2:0] OP_MFC0    = 3'b001;
  localparam logic [2:0] OP_MTC0    = 3'b010;
  localparam logic [2:0] OP_SYSCALL = 3'b011;
  localparam logic [2:0] OP_ERET    = 3'b100;
  localparam logic [2:0] OP_BREAK   = 3'b101;

  localparam logic [4:0] CS_COUNT   = 5'd9;
  localparam logic [4:0] CS_COMPARE = 5'd11;
  localparam logic [4:0] CS_STATUS  = 5'd12;
  localparam logic [4:0] CS_CAUSE   = 5'd13;
  localparam logic [4:0] CS_EPC     = 5'd14;

  logic [31:0] hi_q, lo_q;
  logic [31:0] count_q, compare_q, epc_q;
  logic [7:0]  im_q;
  logic        exl_q, ie_q;
  logic        ti_q;
  logic [1:0]  ip_q;
  logic [4:0]  exc_code_q;

  logic        act;
  logic        is_sys, is_brk, is_eret, is_exc;
  logic        mtc0;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] status_val, cause_val, cp0_rdata;

  assign act     = wr_valid & ~Reset;
  assign is_sys  = act & (wr_cp0Op == OP_SYSCALL);
  assign is_brk  = act & (wr_cp0Op == OP_BREAK);
  assign is_eret = act & (wr_cp0Op == OP_ERET);
  assign is_exc  = is_sys | is_brk;

  // CP0 writes only land on select 0.
  assign mtc0       = act & (wr_cp0Op == OP_MTC0) & (wr_sel == 3'd0);
  assign wr_count   = mtc0 & (wr_cs == CS_COUNT);
  assign wr_compare = mtc0 & (wr_cs == CS_COMPARE);
  assign wr_status  = mtc0 & (wr_cs == CS_STATUS);
  assign wr_cause   = mtc0 & (wr_cs == CS_CAUSE);
  assign wr_epc     = mtc0 & (wr_cs == CS_EPC);

  assign status_val = {16'h0000, im_q, 6'b000000, exl_q, ie_q};
  assign cause_val  = {1'b0, ti_q, 20'h00000, ip_q, 1'b0, exc_code_q, 2'b00};

  always_comb begin
    cp0_rdata = 32'h0000_0000;
    if (wr_sel == 3'd0) begin
      case (wr_cs)
        CS_COUNT:   cp0_rdata = count_q;
        CS_COMPARE: cp0_rdata = compare_q;
        CS_STATUS:  cp0_rdata = status_val;
        CS_CAUSE:   cp0_rdata = cause_val;
        CS_EPC:     cp0_rdata = epc_q;
        default:    cp0_rdata = 32'h0000_0000;
      endcase
    end
  end

  always_comb begin
    rf_wdata = wr_alu_result;
    if (wr_cp0Op == OP_MFC0)
      rf_wdata = cp0_rdata;
    else if (wr_mulToReg)
      rf_wdata = wr_mulRead ? hi_q : lo_q;
    else if (wr_MemtoReg)
      rf_wdata = wr_dout;
  end

  // Exceptions cancel the destination write of the trapping instruction.
  assign rf_we     = act & wr_RegWr & (wr_Rw != 5'd0) & ~is_exc;
  assign rf_waddr  = wr_Rw;

  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign status_o  = status_val;
  assign timer_int = ti_q & im_q[7] & ie_q & ~exl_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (act) begin
      case (wr_regToMul)
        2'b01:   hi_q <= wr_busA;
        2'b10:   lo_q <= wr_busA;
        2'b11: begin
          hi_q <= wr_mul_result[63:32];
          lo_q <= wr_mul_result[31:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      exc_flush  <= 1'b0;
      exc_target <= '0;
    end else begin
      // Count ticks regardless of slot validity; a software write wins.
      if (wr_count) count_q <= wr_busB;
      else          count_q <= count_q + 32'd1;

      if (wr_compare) compare_q <= wr_busB;

      // Match uses the pre-increment Count; Compare==0 disarms the timer.
      if (wr_compare)
        ti_q <= 1'b0;
      else if ((count_q == compare_q) && (compare_q != 32'd0))
        ti_q <= 1'b1;

      if (wr_status) begin
        im_q  <= wr_busB[15:8];
        exl_q <= wr_busB[1];
        ie_q  <= wr_busB[0];
      end else if (is_exc) begin
        exl_q <= 1'b1;
      end else if (is_eret) begin
        exl_q <= 1'b0;
      end

      if (wr_cause) ip_q <= wr_busB[9:8];
      if (is_exc)   exc_code_q <= is_brk ? 5'd9 : 5'd8;

      // Nested traps keep the original return address.
      if (wr_epc)
        epc_q <= wr_busB;
      else if (is_exc && !exl_q)
        epc_q <= {wr_PC, 2'b00};

      exc_flush <= is_exc | is_eret;
      if (is_exc)
        exc_target <= EXC_VECTOR[31:2];
      else if (is_eret)
        exc_target <= epc_q[31:2];
    end
  end

endmodule
